// File: rtl/serializer_tx_pkg.sv
// Shared constants and FSM encoding for the serializer transmit path.
// Optional feature macro used by the top: SERIALIZER_TX_IDLE_COMMA_EN.
package serializer_tx_pkg;

  localparam int         BITS_DEFAULT = 8;
  localparam logic [7:0] COMMA        = 8'hBC;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serializer_tx_shift_reg.sv
// W-bit loadable right-shift register; the LSB is the serial output.
// Zeros are shifted in at the MSB so a fully shifted word leaves the line at 0.
module ser_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         sout_o
);

  logic [W-1:0] shift_q;
  logic [W-1:0] shift_d;

  // Load has priority over shift.
  always_comb begin
    if (load_i) begin
      shift_d = din_i;
    end else if (shift_i) begin
      shift_d = {1'b0, shift_q[W-1:1]};
    end else begin
      shift_d = shift_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= {W{1'b0}};
    end else begin
      shift_q <= shift_d;
    end
  end

  assign sout_o = shift_q[0];

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter, LSB first, with DK flag and bit-0 frame marker.
// Define SERIALIZER_TX_IDLE_COMMA_EN to fill idle time with DK=1 commas.
module serializer_tx
  import serializer_tx_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [BITS-1:0] in,
  input  logic            in_DK,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            data,
  output logic            DK,
  output logic            frame,
  output logic [15:0]     tx_count
);

  localparam int            CW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            dk_q, dk_d;
  logic            frame_q, frame_d;
  logic [15:0]     tx_count_q, tx_count_d;
  logic            last_s;
  logic            accept_s;
  logic            load_s;
  logic            count_s;
  logic [BITS-1:0] load_word_s;
  logic            load_dk_s;

  assign last_s   = (state_q == SHIFT) && (bit_cnt_q == LAST);
  assign accept_s = in_valid && in_ready;

`ifdef SERIALIZER_TX_IDLE_COMMA_EN
  logic comma_q, comma_d;

  // Every ready slot loads something: the offered word, or a comma if none.
  assign load_s      = in_ready;
  assign load_word_s = accept_s ? in : BITS'(COMMA);
  assign load_dk_s   = accept_s ? in_DK : 1'b1;
  assign count_s     = last_s && !comma_q;
  assign comma_d     = load_s ? !accept_s : comma_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      comma_q <= 1'b0;
    end else begin
      comma_q <= comma_d;
    end
  end
`else
  assign load_s      = accept_s;
  assign load_word_s = in;
  assign load_dk_s   = in_DK;
  assign count_s     = last_s;
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load_s ? SHIFT : IDLE;
      SHIFT:   state_d = (last_s && !load_s) ? IDLE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      SHIFT:   in_ready = last_s;
      default: in_ready = 1'b0;
    endcase
  end

  // Counter, DK and frame next-state; DK clears whenever the line goes idle.
  always_comb begin
    bit_cnt_d  = {CW{1'b0}};
    dk_d       = 1'b0;
    frame_d    = load_s;
    tx_count_d = count_s ? (tx_count_q + 16'd1) : tx_count_q;
    if (load_s) begin
      bit_cnt_d = {CW{1'b0}};
      dk_d      = load_dk_s;
    end else if ((state_q == SHIFT) && !last_s) begin
      bit_cnt_d = bit_cnt_q + CW'(1);
      dk_d      = dk_q;
    end else begin
      bit_cnt_d = {CW{1'b0}};
      dk_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q  <= {CW{1'b0}};
      dk_q       <= 1'b0;
      frame_q    <= 1'b0;
      tx_count_q <= 16'd0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      dk_q       <= dk_d;
      frame_q    <= frame_d;
      tx_count_q <= tx_count_d;
    end
  end

  ser_shift_reg #(.W(BITS)) u_shift (
    .clk_i   (clk),
    .rst_ni  (reset_L),
    .load_i  (load_s),
    .shift_i (state_q == SHIFT),
    .din_i   (load_word_s),
    .sout_o  (data)
  );

  assign DK       = dk_q;
  assign frame    = frame_q;
  assign tx_count = tx_count_q;

endmodule
